// File: rtl/bp_be_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_be_pkg
// Purpose  : Shared types for the backend stride prefetcher: processor config
//            selector, stream entry state enum and the stream entry struct
//            macro (parameterized by vaddr, stride, page tag and count widths).
// Revision : 1.0 - initial release
// ============================================================================
`ifndef BP_BE_PF_STREAM_S_DECLARED
`define BP_BE_PF_STREAM_S_DECLARED
`define DECLARE_BP_BE_PF_STREAM_S(vaddr_width_mp, stride_width_mp, tag_width_mp, rem_width_mp) \
  typedef struct packed {                          \
    bp_be_pf_state_e              state;           \
    logic [vaddr_width_mp-1:0]    pc;              \
    logic [stride_width_mp-1:0]   stride;          \
    logic [vaddr_width_mp-1:0]    next_addr;       \
    logic [tag_width_mp-1:0]      page_tag;        \
    logic [rem_width_mp-1:0]      remaining;       \
  } bp_be_pf_stream_s;
`endif

package bp_be_pkg;

  typedef enum logic {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  function automatic int bp_vaddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: bp_vaddr_width = 39;
      default:          bp_vaddr_width = 39;
    endcase
  endfunction

  typedef enum logic [1:0] {
    e_idle   = 2'd0,
    e_train  = 2'd1,
    e_active = 2'd2
  } bp_be_pf_state_e;

endpackage
`default_nettype wire

// File: rtl/bp_be_pf_stream.sv
`default_nettype none
// ============================================================================
// Module   : bp_be_pf_stream
// Purpose  : One tracked stride stream: entry register, update/issue muxing
//            and the page-crossing check for its next candidate address.
// Ports    : clk_i, reset_n_i (sync, active-low)
//            upd_i/hit_i/confirm_i/stride_i/pc_i/eff_addr_i : RPT write
//            kill_train_i : drop this entry if it is still training
//            gnt_i        : arbiter consumed this entry's candidate
//            idle_o, pc_o : CAM view; req_o : has prefetches pending
//            next_addr_o, cross_o : candidate address and its page check
// Revision : 1.0 - initial release
// ============================================================================
module bp_be_pf_stream
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p       = 39,
  parameter int stride_width_p      = 8,
  parameter int degree_p            = 4,
  parameter int page_offset_width_p = 12
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      upd_i,
  input  logic                      hit_i,
  input  logic                      confirm_i,
  input  logic                      kill_train_i,
  input  logic [stride_width_p-1:0] stride_i,
  input  logic [vaddr_width_p-1:0]  pc_i,
  input  logic [vaddr_width_p-1:0]  eff_addr_i,
  input  logic                      gnt_i,
  output logic                      idle_o,
  output logic [vaddr_width_p-1:0]  pc_o,
  output logic                      req_o,
  output logic [vaddr_width_p-1:0]  next_addr_o,
  output logic                      cross_o
);

  localparam int rem_width_lp = $clog2(degree_p + 1);
  localparam int tag_width_lp = vaddr_width_p - page_offset_width_p;

  `DECLARE_BP_BE_PF_STREAM_S(vaddr_width_p, stride_width_p, tag_width_lp, rem_width_lp)

  bp_be_pf_stream_s entry_q, entry_d;

  logic [vaddr_width_p-1:0] cur_stride_sext;
  logic [vaddr_width_p-1:0] new_stride_sext;

  assign cur_stride_sext = {{(vaddr_width_p-stride_width_p){entry_q.stride[stride_width_p-1]}}, entry_q.stride};
  assign new_stride_sext = {{(vaddr_width_p-stride_width_p){stride_i[stride_width_p-1]}}, stride_i};

  assign idle_o      = (entry_q.state == e_idle);
  assign pc_o        = entry_q.pc;
  assign next_addr_o = entry_q.next_addr;
  assign req_o       = (entry_q.state == e_active) && (entry_q.remaining != '0);
  // Wrap-around of next_addr also changes the page bits, so it is caught here.
  assign cross_o     = (entry_q.next_addr[vaddr_width_p-1:page_offset_width_p] != entry_q.page_tag);

  always_comb begin
    entry_d = entry_q;

    // Issue side: a crossing candidate retires the stream's burst without
    // advancing; the entry remains active so a later hit can restart it.
    if (gnt_i) begin
      if (cross_o) begin
        entry_d.remaining = '0;
      end else begin
        entry_d.next_addr = entry_q.next_addr + cur_stride_sext;
        entry_d.remaining = entry_q.remaining - rem_width_lp'(1);
      end
    end

    if (kill_train_i && (entry_q.state == e_train)) begin
      entry_d.state = e_idle;
    end

    // Update is applied last so it overrides any same-cycle issue effects.
    if (upd_i) begin
      entry_d.pc        = pc_i;
      entry_d.stride    = stride_i;
      entry_d.next_addr = eff_addr_i + new_stride_sext;
      entry_d.page_tag  = eff_addr_i[vaddr_width_p-1:page_offset_width_p];
      // "Already active" only means something for the stream that hit; a
      // freshly allocated (replaced) slot does not inherit the old stream.
      if ((stride_i != '0) && (confirm_i || (hit_i && (entry_q.state == e_active)))) begin
        entry_d.state     = e_active;
        entry_d.remaining = rem_width_lp'(degree_p);
      end else begin
        entry_d.state     = e_train;
        entry_d.remaining = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bp_be_stride_pf_gen.sv
`default_nettype none
// ============================================================================
// Module   : bp_be_stride_pf_gen
// Purpose  : Stride prefetch request generator. Tracks streams_p load streams
//            from RPT predictions and issues degree_p prefetch addresses per
//            confirmed stream, one per cycle, stopping at 4 KiB pages.
// Ports    : clk_i, reset_n_i (sync, active-low)
//            stride_v_i, stride_i, pc_i, eff_addr_i, start_discovery_i,
//            confirm_discovery_i : RPT prediction inputs
//            pf_v_o, pf_addr_o, pf_ready_i : D$ prefetch valid/ready port
//            busy_o : requests pending or output valid
// Config   : BP_BE_PF_LINE_DEDUP_EN - suppress candidates that fall in the
//            same cache line as the last address loaded for issue.
// Revision : 1.0 - initial release
// ============================================================================
module bp_be_stride_pf_gen
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p         = e_bp_default_cfg,
  parameter int         streams_p           = 4,
  parameter int         degree_p            = 4,
  parameter int         stride_width_p      = 8,
  parameter int         page_offset_width_p = 12,
  parameter int         line_offset_width_p = 6,
  localparam int        vaddr_width_p       = bp_vaddr_width(bp_params_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      stride_v_i,
  input  logic [stride_width_p-1:0] stride_i,
  input  logic [vaddr_width_p-1:0]  pc_i,
  input  logic [vaddr_width_p-1:0]  eff_addr_i,
  input  logic                      start_discovery_i,
  input  logic                      confirm_discovery_i,
  output logic                      pf_v_o,
  output logic [vaddr_width_p-1:0]  pf_addr_o,
  input  logic                      pf_ready_i,
  output logic                      busy_o
);

  localparam int idx_w_lp = (streams_p > 1) ? $clog2(streams_p) : 1;

  logic [streams_p-1:0]     idle_vec, req_vec, cross_vec;
  logic [vaddr_width_p-1:0] pc_arr   [streams_p];
  logic [vaddr_width_p-1:0] next_arr [streams_p];

  logic                hit, idle_found;
  logic [idx_w_lp-1:0] hit_idx, idle_idx, target_idx, cand_idx;
  logic [idx_w_lp-1:0] victim_q, victim_d, rr_q, rr_d, gnt_idx;
  logic                gnt_v, out_free, load, dedup_hit, win_cross;
  logic [vaddr_width_p-1:0] win_addr;

  logic                     pf_v_q, pf_v_d;
  logic [vaddr_width_p-1:0] pf_addr_q, pf_addr_d;

  // PC CAM over non-idle entries plus lowest-index idle slot search.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    idle_found = 1'b0;
    idle_idx   = '0;
    for (int i = 0; i < streams_p; i++) begin
      if (!idle_vec[i] && (pc_arr[i] == pc_i) && !hit) begin
        hit     = 1'b1;
        hit_idx = idx_w_lp'(i);
      end
      if (idle_vec[i] && !idle_found) begin
        idle_found = 1'b1;
        idle_idx   = idx_w_lp'(i);
      end
    end
  end

  assign target_idx = hit ? hit_idx : (idle_found ? idle_idx : victim_q);
  assign victim_d   = (stride_v_i && !hit && !idle_found)
                    ? idx_w_lp'((int'(victim_q) + 1) % streams_p) : victim_q;

  assign out_free = !pf_v_q || pf_ready_i;

  // Round-robin: search starts at rr_q, which points just past the last winner.
  always_comb begin
    gnt_v    = 1'b0;
    gnt_idx  = rr_q;
    cand_idx = '0;
    for (int k = 0; k < streams_p; k++) begin
      cand_idx = idx_w_lp'((int'(rr_q) + k) % streams_p);
      if (out_free && !gnt_v && req_vec[cand_idx]) begin
        gnt_v   = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  assign rr_d      = gnt_v ? idx_w_lp'((int'(gnt_idx) + 1) % streams_p) : rr_q;
  assign win_addr  = next_arr[gnt_idx];
  assign win_cross = cross_vec[gnt_idx];

  for (genvar i = 0; i < streams_p; i++) begin : g_stream
    logic upd;
    assign upd = stride_v_i && (target_idx == idx_w_lp'(i));

    bp_be_pf_stream #(
      .vaddr_width_p       (vaddr_width_p),
      .stride_width_p      (stride_width_p),
      .degree_p            (degree_p),
      .page_offset_width_p (page_offset_width_p)
    ) u_stream (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .upd_i        (upd),
      .hit_i        (hit),
      .confirm_i    (confirm_discovery_i),
      .kill_train_i (stride_v_i && start_discovery_i && !upd),
      .stride_i     (stride_i),
      .pc_i         (pc_i),
      .eff_addr_i   (eff_addr_i),
      .gnt_i        (gnt_v && (gnt_idx == idx_w_lp'(i))),
      .idle_o       (idle_vec[i]),
      .pc_o         (pc_arr[i]),
      .req_o        (req_vec[i]),
      .next_addr_o  (next_arr[i]),
      .cross_o      (cross_vec[i])
    );
  end

`ifdef BP_BE_PF_LINE_DEDUP_EN
  localparam int line_width_lp = vaddr_width_p - line_offset_width_p;

  logic [line_width_lp-1:0] line_q, line_d;
  logic                     line_v_q, line_v_d;

  assign dedup_hit = line_v_q && (win_addr[vaddr_width_p-1:line_offset_width_p] == line_q);
  assign line_d    = load ? win_addr[vaddr_width_p-1:line_offset_width_p] : line_q;
  assign line_v_d  = line_v_q || load;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      line_q   <= '0;
      line_v_q <= 1'b0;
    end else begin
      line_q   <= line_d;
      line_v_q <= line_v_d;
    end
  end
`else
  assign dedup_hit = 1'b0;
`endif

  // A granted candidate is always consumed; it is loaded only if it stays
  // within its page and is not a duplicate line.
  assign load      = gnt_v && !win_cross && !dedup_hit;
  assign pf_v_d    = out_free ? load : pf_v_q;
  assign pf_addr_d = load ? win_addr : pf_addr_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      pf_v_q    <= 1'b0;
      pf_addr_q <= '0;
      victim_q  <= '0;
      rr_q      <= '0;
    end else begin
      pf_v_q    <= pf_v_d;
      pf_addr_q <= pf_addr_d;
      victim_q  <= victim_d;
      rr_q      <= rr_d;
    end
  end

  assign pf_v_o    = pf_v_q;
  assign pf_addr_o = pf_addr_q;
  assign busy_o    = (|req_vec) || pf_v_q;

endmodule
`default_nettype wire
